// File: rtl/a25_copro_pkg.sv
// Shared constants and types for the Amber 25 CP15 system-control block.
package a25_copro_pkg;

  localparam int unsigned FAULT_STATUS_W = 8;
  localparam int unsigned FAULT_ADDR_W   = 32;
  localparam int unsigned FAULT_ENTRY_W  = FAULT_STATUS_W + FAULT_ADDR_W;

  // Coprocessor operation codes on i_copro_operation.
  localparam logic [1:0] COPRO_MRC = 2'd1;
  localparam logic [1:0] COPRO_MCR = 2'd2;

  // CP15 register numbers.
  localparam logic [3:0] CRN_ID           = 4'd0;
  localparam logic [3:0] CRN_FLUSH        = 4'd1;
  localparam logic [3:0] CRN_CACHE_CTRL   = 4'd2;
  localparam logic [3:0] CRN_CACHEABLE    = 4'd3;
  localparam logic [3:0] CRN_UPDATEABLE   = 4'd4;
  localparam logic [3:0] CRN_DISRUPTIVE   = 4'd5;
  localparam logic [3:0] CRN_FAULT_STATUS = 4'd6;
  localparam logic [3:0] CRN_FAULT_ADDR   = 4'd7;
  localparam logic [3:0] CRN_FAULT_INFO   = 4'd8;

  // Cache flush handshake states.
  typedef enum logic {
    FS_IDLE  = 1'b0,
    FS_FLUSH = 1'b1
  } flush_state_t;

  // One queued fault record.
  typedef struct packed {
    logic [FAULT_STATUS_W-1:0] status;
    logic [FAULT_ADDR_W-1:0]   address;
  } fault_entry_t;

endpackage

// File: rtl/a25_fault_fifo.sv
// Fault record FIFO: power-of-two depth, drop-on-full unless a pop frees a slot.
module a25_fault_fifo
  import a25_copro_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [FAULT_ENTRY_W-1:0] i_data,
  output logic [FAULT_ENTRY_W-1:0] o_head_c,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full_c,
  output logic                     o_empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FAULT_ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic                     w_do_pop;
  logic                     w_do_push;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_head_c  = r_mem[r_rd_ptr];

  // A pop on an empty FIFO does nothing; a push on a full FIFO only lands if a pop frees a slot.
  assign w_do_pop  = i_pop & ~o_empty_c;
  assign w_do_push = i_push & (~o_full_c | w_do_pop);

  // Storage array, written at the write pointer.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/a25_copro15_ext.sv
// CP15 system-control block: control registers, region masks, fault queue and cache flush handshake.
module a25_copro15_ext
  import a25_copro_pkg::*;
#(
  parameter int unsigned NUM_REGIONS  = 32,
  parameter int unsigned REGION_SHIFT = 21,
  parameter int unsigned FAULT_DEPTH  = 4,
  parameter logic [31:0] CORE_ID      = 32'h4156_0301
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_core_stall,
  input  logic [3:0]             i_copro_crn,
  input  logic [1:0]             i_copro_operation,
  input  logic [31:0]            i_copro_write_data,
  input  logic                   i_fault,
  input  logic [7:0]             i_fault_status,
  input  logic [31:0]            i_fault_address,
  input  logic                   i_access_valid,
  input  logic [31:0]            i_access_address,
  output logic [31:0]            o_copro_read_data,
  output logic                   o_cache_enable,
  output logic                   o_cache_flush_req,
  input  logic                   i_cache_flush_ack,
  output logic                   o_copro_busy,
  output logic                   o_access_cacheable,
  output logic                   o_access_updateable,
  output logic [NUM_REGIONS-1:0] o_cacheable_area
);

  localparam int unsigned LOG2_REGIONS = $clog2(NUM_REGIONS);
  localparam int unsigned IDX_W        = (LOG2_REGIONS == 0) ? 1 : LOG2_REGIONS;
  localparam int unsigned TOP_SHIFT    = REGION_SHIFT + LOG2_REGIONS;
  localparam int unsigned CNT_W        = $clog2(FAULT_DEPTH) + 1;

  logic [2:0]             r_cache_control;
  logic [NUM_REGIONS-1:0] r_cacheable;
  logic [NUM_REGIONS-1:0] r_updateable;
  logic [NUM_REGIONS-1:0] r_disruptive;
  logic                   r_overflow;
  logic [31:0]            r_read_data;
  logic                   r_acc_cacheable;
  logic                   r_acc_updateable;
  flush_state_t           r_state;
  flush_state_t           w_state_nxt;
  logic                   r_pending;
  logic                   w_pending_nxt;
  logic                   r_flush_req;
  logic                   r_busy;

  logic                   w_mcr;
  logic                   w_mrc;
  logic                   w_fault_push;
  logic                   w_fault_pop;
  logic                   w_out_of_range;
  logic [IDX_W-1:0]       w_region_idx;
  logic [NUM_REGIONS-1:0] w_region_onehot;
  logic                   w_hit_cacheable;
  logic                   w_hit_updateable;
  logic                   w_hit_disruptive;
  logic                   w_flush_request;
  logic [31:0]            w_read_mux;
  fault_entry_t           w_push_entry;
  fault_entry_t           w_head;
  logic [CNT_W-1:0]       w_count;
  logic                   w_full;
  logic                   w_empty;

  assign w_mcr        = (i_copro_operation == COPRO_MCR) & ~i_core_stall;
  assign w_mrc        = (i_copro_operation == COPRO_MRC) & ~i_core_stall;
  assign w_fault_push = i_fault & ~i_core_stall;
  assign w_fault_pop  = w_mcr & (i_copro_crn == CRN_FAULT_STATUS);

  assign w_push_entry = '{status: i_fault_status, address: i_fault_address};

  a25_fault_fifo #(
    .DEPTH (FAULT_DEPTH)
  ) u_fault_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (w_fault_push),
    .i_pop     (w_fault_pop),
    .i_data    (w_push_entry),
    .o_head_c  (w_head),
    .o_count   (w_count),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  // Region decode: any address bit above the region index field puts the access out of range.
  assign w_out_of_range   = (i_access_address >> TOP_SHIFT) != 32'd0;
  assign w_region_idx     = (LOG2_REGIONS == 0) ? '0 : IDX_W'(i_access_address >> REGION_SHIFT);
  assign w_region_onehot  = NUM_REGIONS'(1) << w_region_idx;
  assign w_hit_cacheable  = ~w_out_of_range & (|(r_cacheable & w_region_onehot));
  assign w_hit_updateable = ~w_out_of_range & (|(r_updateable & w_region_onehot));
  assign w_hit_disruptive = ~w_out_of_range & (|(r_disruptive & w_region_onehot));

  assign w_flush_request = (w_mcr & (i_copro_crn == CRN_FLUSH)) | (i_access_valid & w_hit_disruptive);

  // MCR register writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cache_control <= '0;
      r_cacheable     <= '0;
      r_updateable    <= '0;
      r_disruptive    <= '0;
    end else if (w_mcr) begin
      case (i_copro_crn)
        CRN_CACHE_CTRL: r_cache_control <= i_copro_write_data[2:0];
        CRN_CACHEABLE:  r_cacheable     <= i_copro_write_data[NUM_REGIONS-1:0];
        CRN_UPDATEABLE: r_updateable    <= i_copro_write_data[NUM_REGIONS-1:0];
        CRN_DISRUPTIVE: r_disruptive    <= i_copro_write_data[NUM_REGIONS-1:0];
        default: ;
      endcase
    end
  end

  // Overflow flag: set by a dropped push, cleared by a pop (a pop never drops, so no conflict).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_fault_push && w_full && !w_fault_pop) begin
      r_overflow <= 1'b1;
    end else if (w_fault_pop) begin
      r_overflow <= 1'b0;
    end
  end

  // MRC read mux; an empty FIFO reads as zero.
  always_comb begin
    w_read_mux = 32'd0;
    case (i_copro_crn)
      CRN_ID:           w_read_mux = CORE_ID;
      CRN_CACHE_CTRL:   w_read_mux = 32'(r_cache_control);
      CRN_CACHEABLE:    w_read_mux = 32'(r_cacheable);
      CRN_UPDATEABLE:   w_read_mux = 32'(r_updateable);
      CRN_DISRUPTIVE:   w_read_mux = 32'(r_disruptive);
      CRN_FAULT_STATUS: w_read_mux = w_empty ? 32'd0 : 32'(w_head.status);
      CRN_FAULT_ADDR:   w_read_mux = w_empty ? 32'd0 : w_head.address;
      CRN_FAULT_INFO:   w_read_mux = {r_overflow, 23'd0, 8'(w_count)};
      default:          w_read_mux = 32'd0;
    endcase
  end

  // Registered read data, held while stalled or idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_read_data <= '0;
    end else if (w_mrc) begin
      r_read_data <= w_read_mux;
    end
  end

  // Access lookup results, held between strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc_cacheable  <= 1'b0;
      r_acc_updateable <= 1'b0;
    end else if (i_access_valid) begin
      r_acc_cacheable  <= w_hit_cacheable & r_cache_control[0];
      r_acc_updateable <= w_hit_updateable;
    end
  end

  // Flush FSM state, pending flag and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= FS_IDLE;
      r_pending   <= 1'b0;
      r_flush_req <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_flush_req <= (w_state_nxt == FS_FLUSH);
      r_busy      <= (w_state_nxt == FS_FLUSH) | w_pending_nxt;
    end
  end

  // Flush FSM next state: requests during FLUSH are remembered and replayed after one IDLE cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    case (r_state)
      FS_IDLE: begin
        if (r_pending || w_flush_request) begin
          w_state_nxt   = FS_FLUSH;
          w_pending_nxt = 1'b0;
        end
      end
      FS_FLUSH: begin
        if (w_flush_request) begin
          w_pending_nxt = 1'b1;
        end
        if (i_cache_flush_ack) begin
          w_state_nxt = FS_IDLE;
        end
      end
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  assign o_copro_read_data   = r_read_data;
  assign o_cache_enable      = r_cache_control[0];
  assign o_cache_flush_req   = r_flush_req;
  assign o_copro_busy        = r_busy;
  assign o_access_cacheable  = r_acc_cacheable;
  assign o_access_updateable = r_acc_updateable;
  assign o_cacheable_area    = r_cacheable;

endmodule
